// File: rtl/layer_pkg.sv
// Shared defaults and the per-channel activation arithmetic for the
// layer post-processing / pooling block.
package layer_pkg;

    localparam int PSUM_W_DEF  = 23;
    localparam int OUT_W_DEF   = 8;
    localparam int SHIFT_W_DEF = 5;

    // ReLU, arithmetic right shift (truncating) and saturation to out_max.
    // Operands are carried at a generous fixed width so any channel geometry
    // up to 64-bit partial sums and 31-bit activations fits.
    function automatic logic [31:0] relu_descale_sat(
        input logic signed [63:0] psum,
        input logic [7:0]         shift,
        input logic [31:0]        out_max
    );
        logic [63:0] mag;
        logic [63:0] descaled;
        logic [31:0] result;
        mag      = psum;
        descaled = mag >> shift;
        if (psum < 0) begin
            result = 32'd0;
        end else if (descaled > {32'd0, out_max}) begin
            result = out_max;
        end else begin
            result = descaled[31:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/act_descale_sat.sv
// One channel of ReLU / descale / saturate, purely combinational.
module act_descale_sat
    import layer_pkg::*;
#(
    parameter int PSUM_W  = PSUM_W_DEF,
    parameter int OUT_W   = OUT_W_DEF,
    parameter int SHIFT_W = SHIFT_W_DEF
) (
    input  logic [PSUM_W-1:0]  psum,
    input  logic [SHIFT_W-1:0] shift,
    output logic [OUT_W-1:0]   act
);

    localparam logic [31:0] OUT_MAX = 32'((64'd1 << OUT_W) - 64'd1);

    logic signed [63:0] psum_ext;

    assign psum_ext = {{(64-PSUM_W){psum[PSUM_W-1]}}, psum};
    assign act      = OUT_W'(relu_descale_sat(psum_ext, 8'(shift), OUT_MAX));

endmodule

// File: rtl/layer_postproc_pool.sv
// Activation post-processing with optional 2x2 max-pool.
// Stage A: per-channel ReLU/descale/saturate, registered.
// Stage B: bypass, or horizontal pair max + line buffer vertical max.
module layer_postproc_pool
    import layer_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int PSUM_W  = PSUM_W_DEF,
    parameter int OUT_W   = OUT_W_DEF,
    parameter int IMG_W   = 16,
    parameter int IMG_H   = 16,
    parameter int SHIFT_W = SHIFT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_vld,
    input  logic                  i_sof,
    input  logic [NCH*PSUM_W-1:0] i_psum,
    input  logic [SHIFT_W-1:0]    i_shift,
    input  logic                  i_pool_en,
    output logic                  o_vld,
    output logic [NCH*OUT_W-1:0]  o_data,
    output logic                  o_frame_done
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LB_D  = IMG_W / 2;
    localparam int LB_AW = (LB_D > 1) ? $clog2(LB_D) : 1;
    localparam int VEC_W = NCH * OUT_W;

    // Position and per-frame configuration
    logic [COL_W-1:0]   col_reg, cur_col;
    logic [ROW_W-1:0]   row_reg, cur_row;
    logic [SHIFT_W-1:0] shift_q, shift_eff;
    logic               pool_q, pool_eff;
    logic               sof_hit;

    // Stage A
    logic [VEC_W-1:0]   act_vec;
    logic               a_vld_reg;
    logic [VEC_W-1:0]   a_data_reg;
    logic               a_col_odd_reg, a_row_odd_reg, a_pool_reg, a_last_reg;
    logic [LB_AW-1:0]   a_lb_idx_reg;

    // Pooling state
    logic [VEC_W-1:0]   hold_reg;
    logic [VEC_W-1:0]   line_buf [LB_D];
    logic [VEC_W-1:0]   lb_rd, hmax, vmax;

    // The start-of-frame pixel uses its own configuration and coordinates
    assign sof_hit   = i_vld & i_sof;
    assign cur_col   = sof_hit ? '0 : col_reg;
    assign cur_row   = sof_hit ? '0 : row_reg;
    assign shift_eff = sof_hit ? i_shift : shift_q;
    assign pool_eff  = sof_hit ? i_pool_en : pool_q;
    assign lb_rd     = line_buf[a_lb_idx_reg];

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [OUT_W-1:0] cur_ch, hold_ch, hmax_ch, lb_ch;

        act_descale_sat #(
            .PSUM_W  (PSUM_W),
            .OUT_W   (OUT_W),
            .SHIFT_W (SHIFT_W)
        ) u_act (
            .psum  (i_psum[gi*PSUM_W +: PSUM_W]),
            .shift (shift_eff),
            .act   (act_vec[gi*OUT_W +: OUT_W])
        );

        assign cur_ch  = a_data_reg[gi*OUT_W +: OUT_W];
        assign hold_ch = hold_reg[gi*OUT_W +: OUT_W];
        assign lb_ch   = lb_rd[gi*OUT_W +: OUT_W];
        assign hmax_ch = (cur_ch > hold_ch) ? cur_ch : hold_ch;
        assign hmax[gi*OUT_W +: OUT_W] = hmax_ch;
        assign vmax[gi*OUT_W +: OUT_W] = (hmax_ch > lb_ch) ? hmax_ch : lb_ch;
    end

    // Raster counters and per-frame configuration, advanced only by valid pixels
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_reg <= '0;
            row_reg <= '0;
            shift_q <= '0;
            pool_q  <= 1'b0;
        end else if (i_vld) begin
            if (sof_hit) begin
                shift_q <= i_shift;
                pool_q  <= i_pool_en;
            end
            if (cur_col == COL_W'(IMG_W - 1)) begin
                col_reg <= '0;
                row_reg <= (cur_row == ROW_W'(IMG_H - 1)) ? '0 : cur_row + 1'b1;
            end else begin
                col_reg <= cur_col + 1'b1;
                row_reg <= cur_row;
            end
        end
    end

    // Stage A register: activations plus the pixel's position tags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_vld_reg     <= 1'b0;
            a_data_reg    <= '0;
            a_col_odd_reg <= 1'b0;
            a_row_odd_reg <= 1'b0;
            a_pool_reg    <= 1'b0;
            a_last_reg    <= 1'b0;
            a_lb_idx_reg  <= '0;
        end else begin
            a_vld_reg <= i_vld;
            if (i_vld) begin
                a_data_reg    <= act_vec;
                a_col_odd_reg <= cur_col[0];
                a_row_odd_reg <= cur_row[0];
                a_pool_reg    <= pool_eff;
                a_last_reg    <= (cur_col == COL_W'(IMG_W - 1)) &&
                                 (cur_row == ROW_W'(IMG_H - 1));
                a_lb_idx_reg  <= LB_AW'(cur_col >> 1);
            end
        end
    end

    // Stage B: bypass or pooling; outputs are zero when not valid
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_vld        <= 1'b0;
            o_data       <= '0;
            o_frame_done <= 1'b0;
            hold_reg     <= '0;
        end else begin
            o_vld        <= 1'b0;
            o_data       <= '0;
            o_frame_done <= 1'b0;
            if (a_vld_reg) begin
                if (!a_pool_reg) begin
                    o_vld        <= 1'b1;
                    o_data       <= a_data_reg;
                    o_frame_done <= a_last_reg;
                end else if (!a_col_odd_reg) begin
                    hold_reg <= a_data_reg;
                end else if (a_row_odd_reg) begin
                    o_vld        <= 1'b1;
                    o_data       <= vmax;
                    o_frame_done <= a_last_reg;
                end
            end
        end
    end

    // Line buffer: even-row horizontal maxima, consumed by the following odd row
    always_ff @(posedge clk) begin
        if (a_vld_reg && a_pool_reg && a_col_odd_reg && !a_row_odd_reg) begin
            line_buf[a_lb_idx_reg] <= hmax;
        end
    end

endmodule

// File: tb/tb_layer_postproc_pool.sv
// Self-checking bench for layer_postproc_pool on a 4x4, 4-channel geometry.
module tb_layer_postproc_pool;

    localparam int NCH = 4;
    localparam int PW  = 23;
    localparam int OW  = 8;
    localparam int W   = 4;
    localparam int H   = 4;

    logic              clk = 1'b0;
    logic              rstn;
    logic              i_vld, i_sof, i_pool_en;
    logic [NCH*PW-1:0] i_psum;
    logic [4:0]        i_shift;
    logic              o_vld, o_frame_done;
    logic [NCH*OW-1:0] o_data;

    layer_postproc_pool #(
        .NCH(NCH), .PSUM_W(PW), .OUT_W(OW), .IMG_W(W), .IMG_H(H), .SHIFT_W(5)
    ) dut (
        .clk(clk), .rstn(rstn), .i_vld(i_vld), .i_sof(i_sof), .i_psum(i_psum),
        .i_shift(i_shift), .i_pool_en(i_pool_en), .o_vld(o_vld), .o_data(o_data),
        .o_frame_done(o_frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        bit          fd;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  got_q[$];
    bit          got_fd[$];
    int          n_total = 0;
    int          n_pass  = 0;
    int          n_fail  = 0;
    int          step_cnt = 0;

    // Reference model state: frame position, configuration and pixel store
    int          m_row, m_col, m_shift;
    bit          m_pool;
    logic [31:0] pix [H][W];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_act(input int psum, input int sh);
        longint q;
        if (psum < 0) return 0;
        q = longint'(psum) / (longint'(1) << sh);
        return (q > 255) ? 255 : int'(q);
    endfunction

    function automatic logic [31:0] win_max(input int r, input int c);
        logic [31:0] res;
        logic [7:0]  v [4];
        logic [7:0]  m;
        for (int k = 0; k < NCH; k++) begin
            v[0] = pix[r-1][c-1][k*8 +: 8];
            v[1] = pix[r-1][c][k*8 +: 8];
            v[2] = pix[r][c-1][k*8 +: 8];
            v[3] = pix[r][c][k*8 +: 8];
            m = 8'd0;
            for (int j = 0; j < 4; j++) if (v[j] > m) m = v[j];
            res[k*8 +: 8] = m;
        end
        return res;
    endfunction

    function automatic int rnd_psum();
        if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 700)) - 100;
        return int'($urandom_range(0, (1 << 23) - 1)) - (1 << 22);
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        m_row = 0; m_col = 0; m_shift = 0; m_pool = 1'b0;
    endfunction

    // One clock cycle: update the model, drive inputs, then check outputs
    task automatic step(input bit vld, input bit sof, input int p0, input int p1,
                        input int p2, input int p3, input int sh, input bit pool);
        int          ps[4];
        logic [31:0] a;
        exp_t        e;
        bit          last;
        ps = '{p0, p1, p2, p3};
        if (vld) begin
            if (sof) begin
                m_row = 0; m_col = 0; m_shift = sh; m_pool = pool;
            end
            for (int k = 0; k < NCH; k++) a[k*8 +: 8] = 8'(ref_act(ps[k], m_shift));
            pix[m_row][m_col] = a;
            last = (m_row == H - 1) && (m_col == W - 1);
            if (!m_pool) begin
                e.data = a; e.fd = last; e.due = step_cnt + 1;
                exp_q.push_back(e);
            end else if ((m_row % 2 == 1) && (m_col % 2 == 1)) begin
                e.data = win_max(m_row, m_col); e.fd = last; e.due = step_cnt + 1;
                exp_q.push_back(e);
            end
            if (m_col == W - 1) begin
                m_col = 0;
                m_row = (m_row == H - 1) ? 0 : m_row + 1;
            end else begin
                m_col = m_col + 1;
            end
        end
        i_vld = vld; i_sof = sof; i_shift = 5'(sh); i_pool_en = pool;
        for (int k = 0; k < NCH; k++) i_psum[k*PW +: PW] = PW'(ps[k]);
        @(posedge clk);
        #1;
        i_vld = 1'b0; i_sof = 1'b0;
        if (o_vld === 1'b1) begin
            got_q.push_back(o_data[7:0]);
            got_fd.push_back(o_frame_done);
        end
        if (exp_q.size() > 0 && exp_q[0].due == step_cnt) begin
            e = exp_q.pop_front();
            $display("step %0d: out expected data=%h fd=%0d got vld=%0b data=%h fd=%0b",
                     step_cnt, e.data, e.fd, o_vld, o_data, o_frame_done);
            chk("o_vld", 32'(o_vld), 32'd1);
            chk("o_data", o_data, e.data);
            chk("o_frame_done", 32'(o_frame_done), 32'(e.fd));
        end else begin
            chk("o_vld_idle", 32'(o_vld), 32'd0);
            chk("o_data_idle", o_data, 32'd0);
            chk("o_frame_done_idle", 32'(o_frame_done), 32'd0);
        end
        step_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic pix_val(input int idx, input int v, input int sh, input bit pool);
        step(1'b1, idx == 0, v, v, v, v, sh, pool);
    endtask

    task automatic pix_rnd(input bit sof, input int sh, input bit pool);
        step(1'b1, sof, rnd_psum(), rnd_psum(), rnd_psum(), rnd_psum(), sh, pool);
    endtask

    task automatic check_pool_seq(input string tag);
        int e40[4];
        e40 = '{5, 7, 13, 15};
        chk({tag, "_count"}, 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            chk({tag, "_val"}, 32'(got_q[i]), 32'(e40[i]));
            chk({tag, "_fd"}, 32'(got_fd[i]), (i == 3) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        rstn = 1'b0; i_vld = 1'b0; i_sof = 1'b0; i_psum = '0; i_shift = '0; i_pool_en = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_o_vld", 32'(o_vld), 32'd0);
        chk("reset_o_data", o_data, 32'd0);
        chk("reset_o_frame_done", 32'(o_frame_done), 32'd0);
        rstn = 1'b1;

        // Pixels before any start-of-frame: shift 0, bypass, position (0,0)
        pix_rnd(1'b0, 9, 1'b1);
        pix_rnd(1'b0, 9, 1'b1);
        idle(2);

        // Bypass frame, shift 7, known descale/saturate vector first
        step(1'b1, 1'b1, -5, 128, 32767, 40000, 7, 1'b0);
        pix_rnd(1'b0, 7, 1'b0);
        chk("bypass_shift7_vector", o_data, 32'hFFFF0100);
        for (int i = 2; i < W * H; i++) pix_rnd(1'b0, 7, 1'b0);
        idle(3);

        // Pool, shift 0, value row*4+col, contiguous
        got_q.delete(); got_fd.delete();
        for (int i = 0; i < W * H; i++) pix_val(i, i, 0, 1'b1);
        idle(3);
        check_pool_seq("pool_ramp");

        // Same frame with a gap after every pixel
        got_q.delete(); got_fd.delete();
        for (int i = 0; i < W * H; i++) begin
            pix_val(i, i, 0, 1'b1);
            idle(1);
        end
        idle(2);
        check_pool_seq("pool_ramp_gaps");

        // Start-of-frame reasserted at (row 1, col 0): old frame abandoned
        got_q.delete(); got_fd.delete();
        for (int i = 0; i < W; i++) pix_rnd(i == 0, 3, 1'b1);
        for (int i = 0; i < W * H; i++) pix_rnd(i == 0, 4, 1'b1);
        idle(3);
        chk("restart_out_count", 32'(got_q.size()), 32'd4);

        // Pool with shift 31 on positive data: all zero
        for (int i = 0; i < W * H; i++)
            step(1'b1, i == 0, $urandom_range(0, (1 << 22) - 1), $urandom_range(0, (1 << 22) - 1),
                 $urandom_range(0, (1 << 22) - 1), $urandom_range(0, (1 << 22) - 1), 31, 1'b1);
        idle(3);

        // Bypass shift 0, psum 300 saturates to 255
        step(1'b1, 1'b1, 300, 300, 300, 300, 0, 1'b0);
        idle(1);
        chk("saturate_300", o_data, 32'hFFFFFFFF);
        idle(2);

        // Reset while an output is being presented
        for (int i = 0; i < W + 2; i++) pix_rnd(i == 0, 2, 1'b1);
        idle(1);
        chk("pre_reset_o_vld", 32'(o_vld), 32'd1);
        rstn = 1'b0;
        #1;
        chk("async_reset_o_vld", 32'(o_vld), 32'd0);
        chk("async_reset_o_data", o_data, 32'd0);
        chk("async_reset_o_frame_done", 32'(o_frame_done), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
        for (int i = 0; i < W + 1; i++) pix_rnd(i == 0, 2, 1'b1);
        idle(3);
        for (int i = 0; i < W * H; i++) pix_rnd(i == 0, 2, 1'b1);
        idle(3);

        // Randomized frames: random mode, shift and input gaps
        for (int f = 0; f < 6; f++) begin
            int  sh;
            bit  pool;
            sh   = $urandom_range(0, 15);
            pool = bit'($urandom_range(0, 1));
            for (int i = 0; i < W * H; i++) begin
                while ($urandom_range(0, 2) == 0) idle(1);
                pix_rnd(i == 0, sh, pool);
            end
        end
        idle(3);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/layer_postproc_pool.md
LAYER_POSTPROC_POOL -- requirements
Module: layer_postproc_pool

Interface
REQ-001 Parameter NCH, default 4, number of parallel channels per pixel.
REQ-002 Parameter PSUM_W, default 23, signed partial-sum width per channel.
REQ-003 Parameter OUT_W, default 8, unsigned activation width per channel.
REQ-004 Parameter IMG_W, default 16, input columns per row (even, >=2).
REQ-005 Parameter IMG_H, default 16, input rows per frame (even, >=2).
REQ-006 Parameter SHIFT_W, default 5, width of the descale shift field.
REQ-007 clk  input  1  single clock, rising edge.
REQ-008 rstn  input  1  asynchronous active-low reset.
REQ-009 i_vld  input  1  input pixel valid, one pixel per asserted cycle, raster order.
REQ-010 i_sof  input  1  start of frame, qualified by i_vld, marks pixel (row 0, col 0).
REQ-011 i_psum  input  NCH*PSUM_W  signed partial sums; channel k at bits [k*PSUM_W +: PSUM_W].
REQ-012 i_shift  input  SHIFT_W  descale right-shift amount, captured on i_vld&i_sof.
REQ-013 i_pool_en  input  1  1 = 2x2 max-pool, 0 = bypass; captured on i_vld&i_sof.
REQ-014 o_vld  output  1  output pixel valid.
REQ-015 o_data  output  NCH*OUT_W  activations; channel k at bits [k*OUT_W +: OUT_W].
REQ-016 o_frame_done  output  1  one-cycle pulse coincident with the last o_vld of a frame.

Function
REQ-017 Stage A (registered): per channel, negative psum -> 0 (ReLU); else psum >>> shift_q (truncate); result > 2^OUT_W-1 -> 2^OUT_W-1 (saturate).
REQ-018 Stage A SHALL register its result and a valid flag one cycle after i_vld.
REQ-019 Column counter 0..IMG_W-1 and row counter 0..IMG_H-1 SHALL advance only on i_vld; column wraps to 0 and increments row; row wraps to 0 after IMG_H-1.
REQ-020 i_vld&i_sof SHALL force counters to (0,0) for that pixel, load shift_q/pool_q, and discard any partial pooling state.
REQ-021 Bypass mode: every stage-A pixel SHALL appear on o_data with o_vld exactly 2 cycles after its i_vld.
REQ-022 Pool mode, even column: stage-A vector SHALL be held in a horizontal register.
REQ-023 Pool mode, odd column: per-channel max(held, current) = hmax.
REQ-024 Pool mode, even row, odd column: hmax SHALL be written to line buffer entry col/2 (IMG_W/2 entries of NCH*OUT_W bits); no output.
REQ-025 Pool mode, odd row, odd column: per-channel max(hmax, linebuf[col/2]) SHALL drive o_data with o_vld 2 cycles after that i_vld.
REQ-026 Pool mode yields (IMG_W/2)*(IMG_H/2) outputs per frame; bypass yields IMG_W*IMG_H.
REQ-027 Comparisons SHALL be unsigned; ties select either operand (identical value).
REQ-028 o_frame_done SHALL assert with the output produced by input (IMG_H-1, IMG_W-1).
REQ-029 Gaps in i_vld SHALL stall all counters and hold pooling state; latency counted from the valid input cycle.
REQ-030 i_sof arriving mid-frame SHALL abandon the old frame without o_frame_done; outputs already in the pipeline for the old frame still emerge.
REQ-031 o_data SHALL be 0 whenever o_vld is 0.
REQ-032 i_shift >= PSUM_W SHALL yield 0 for every channel.

Reset
REQ-033 rstn low SHALL asynchronously clear o_vld, o_data, o_frame_done, counters, stage-A regs, horizontal register, shift_q (0) and pool_q (0).
REQ-034 Line buffer contents need not be reset; they are never read before written in the same frame.
REQ-035 After reset, inputs before the first i_vld&i_sof SHALL be processed with shift_q=0, pool_q=0, counters at (0,0).

Structure
REQ-036 Shared package layer_pkg SHALL hold default PSUM_W, OUT_W, SHIFT_W and a function for per-channel ReLU/descale/saturate.
REQ-037 One sub-module act_descale_sat (one channel, combinational, instantiated NCH times) SHALL implement REQ-017.
REQ-038 Line buffer SHALL be a register array inferable as distributed RAM, one write or read per cycle.

Verification
REQ-039 Bypass, shift 7, psum {-5, 128, 32767, 40000} -> 2 cycles later o_data {0, 1, 255, 255}.
REQ-040 Pool, IMG_W=IMG_H=4, shift 0, pixel value = row*4+col on all channels -> outputs 5, 7, 13, 15 in order, o_frame_done with 15.
REQ-041 Same as REQ-040 with i_vld toggling every other cycle -> identical outputs, each 2 cycles after its odd-row odd-column input.
REQ-042 i_sof reasserted at (row 1, col 0) of a pool frame -> no output from abandoned window, next frame counted from new i_sof.
REQ-043 rstn pulsed low mid-frame -> o_vld/o_data/o_frame_done 0 immediately, no output until new pixels complete a window.
REQ-044 Pool, shift 31 on all-positive input -> all outputs 0; shift 0, psum 300 -> 255.
